// File: rtl/forward_scoreboard.sv
// EX-stage forwarding and load-use hazard unit.
// Tracks the DEPTH instructions ahead of EX in a shift-register scoreboard and
// picks, per source operand, the nearest producer stage to forward from. A load
// that is still too young to forward raises a stall. Stall and forward cycles
// are tallied in saturating counters.
module forward_scoreboard #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       ex_valid_i,
  input  logic                       ex_regwrite_i,
  input  logic                       ex_load_i,
  input  logic [ADDR_W-1:0]          ex_rd_i,
  input  logic [NUM_SRC*ADDR_W-1:0]  ex_rs_addr_i,
  input  logic [NUM_SRC-1:0]         ex_rs_used_i,
  input  logic                       flush_i,
  output logic [NUM_SRC*SEL_W-1:0]   select_o,
  output logic                       stall_o,
  output logic [CNT_W-1:0]           stall_cnt_o,
  output logic [CNT_W-1:0]           fwd_cnt_o
);

  // The select encoding must be able to name every tracked stage.
  if ((1 << SEL_W) <= DEPTH) begin : g_bad_sel_w
    $error("forward_scoreboard: SEL_W too narrow for DEPTH");
  end

  // Scoreboard, index i holds stage k = i + 1 (index 0 is EX/MEM).
  logic [DEPTH-1:0]             v_q, v_d;
  logic [DEPTH-1:0]             load_q, load_d;
  logic [DEPTH-1:0][ADDR_W-1:0] rd_q, rd_d;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;

  logic [NUM_SRC*SEL_W-1:0] select;
  logic [NUM_SRC-1:0]       hazard;
  logic                     found;
  logic                     stall;
  logic                     ex_enter;
  logic                     any_fwd;

  // Per source: nearest matching producer wins; a too-young load is a hazard.
  always_comb begin
    select = '0;
    hazard = '0;
    found  = 1'b0;
    for (int unsigned j = 0; j < NUM_SRC; j++) begin
      found = 1'b0;
      if (ex_valid_i && ex_rs_used_i[j] &&
          (ex_rs_addr_i[j*ADDR_W +: ADDR_W] != '0)) begin
        for (int unsigned k = 1; k <= DEPTH; k++) begin
          if (!found && v_q[k-1] &&
              (rd_q[k-1] == ex_rs_addr_i[j*ADDR_W +: ADDR_W])) begin
            found = 1'b1;
            if (load_q[k-1] && (k <= LOAD_LAT)) begin
              hazard[j] = 1'b1;
            end else begin
              select[j*SEL_W +: SEL_W] = SEL_W'(k);
            end
          end
        end
      end
    end
  end

  // Flush wins over stall; the killed instruction never enters the scoreboard.
  always_comb begin
    stall    = ex_valid_i & ~flush_i & (|hazard);
    any_fwd  = |select;
    ex_enter = ex_valid_i & ~flush_i & ~stall & ex_regwrite_i & (ex_rd_i != '0);
  end

  // Scoreboard advance: older entries always shift; stage 1 takes EX or a bubble.
  always_comb begin
    v_d    = '0;
    load_d = load_q;
    rd_d   = rd_q;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      v_d[k]    = v_q[k-1];
      load_d[k] = load_q[k-1];
      rd_d[k]   = rd_q[k-1];
    end
    v_d[0]    = ex_enter;
    load_d[0] = ex_load_i;
    rd_d[0]   = ex_rd_i;
  end

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (any_fwd && !stall && !(&fwd_cnt_q)) begin
      fwd_cnt_d = fwd_cnt_q + 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      v_q         <= '0;
      load_q      <= '0;
      rd_q        <= '0;
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      v_q         <= v_d;
      load_q      <= load_d;
      rd_q        <= rd_d;
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign select_o    = select;
  assign stall_o     = stall;
  assign stall_cnt_o = stall_cnt_q;
  assign fwd_cnt_o   = fwd_cnt_q;

endmodule

// File: doc/forward_scoreboard.md
Name: forward_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the EX stage; replaces the fixed two-source, two-stage forwarder.
- Keeps its own shift-register scoreboard of the DEPTH instructions ahead of EX (EX/MEM, MEM/WB, ...), with destination, write-enable and load flag per entry.
- Produces a forwarding select per source operand, a load-use stall, and saturating stall/forward event counters.

Parameters:
ADDR_W, 5, register address width
NUM_SRC, 2, number of source operands checked per EX instruction
DEPTH, 2, number of tracked producer stages after EX (stage 1 = EX/MEM)
LOAD_LAT, 1, a load's data is forwardable only from stage k > LOAD_LAT
SEL_W, 2, select width; must satisfy 2^SEL_W > DEPTH
CNT_W, 16, event counter width

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous reset, active-low
ex_valid_i  input  1  instruction in EX is real (not a bubble)
ex_regwrite_i  input  1  EX instruction writes a register
ex_load_i  input  1  EX instruction is a load
ex_rd_i  input  ADDR_W  EX instruction destination
ex_rs_addr_i  input  NUM_SRC*ADDR_W  source j at [j*ADDR_W +: ADDR_W]
ex_rs_used_i  input  NUM_SRC  source j is actually read
flush_i  input  1  kill EX instruction (branch taken)
select_o  output  NUM_SRC*SEL_W  source j at [j*SEL_W +: SEL_W]; 0 = register file, k = forward from stage k
stall_o  output  1  load-use stall; pipeline holds PC/IF/ID/EX this cycle
stall_cnt_o  output  CNT_W  stall cycles counted
fwd_cnt_o  output  CNT_W  cycles with at least one nonzero select

Behaviour:
- Scoreboard entry s[k], k = 1..DEPTH: {v, rd, load}.
- v = 1 only if the instruction was valid, had regwrite set, and had rd != 0.
- Per rising edge, when rst_i = 1:
  - s[k] <= s[k-1] for k >= 2.
  - s[1] <= EX instruction if ex_valid_i & ~flush_i & ~stall_o; otherwise s[1] <= bubble (v = 0).
  - s[DEPTH] falls off the end; the register file is write-first, so no forward is needed beyond DEPTH.
- Select (combinational), for each source j with ex_valid_i & ex_rs_used_j & rs_j != 0:
  - Find the smallest k with s[k].v & s[k].rd == rs_j. The nearest producer always wins.
  - If no k matches, sel = 0.
  - If a match is found and not (s[k].load & k <= LOAD_LAT), sel = k.
  - Otherwise the source has a hazard: sel = 0.
- Any unused source, or a source with rs = 0: sel = 0.
- stall_o = ex_valid_i & ~flush_i & (OR of per-source hazards). Combinational, same cycle.
- While stalled, the environment re-presents the same EX instruction next cycle.
- A bubble enters s[1] while older entries keep advancing, so a load at stage 1 reaches stage 2 after one stall cycle. With LOAD_LAT=1, that gives exactly one stall cycle.
- flush_i beats stall: stall_o = 0 and a bubble enters s[1].
- Counters, updated on a clock edge with rst_i = 1:
  - stall_cnt_o increments when stall_o = 1.
  - fwd_cnt_o increments when any select is nonzero and stall_o = 0.
  - Both saturate at 2^CNT_W - 1; they do not wrap.
- Reset (rst_i = 0 at an edge):
  - All s[k].v = 0 and both counters = 0.
  - As a result select_o = 0 and stall_o = 0 whenever the inputs are idle.
  - Reset mid-stall discards the pending load. There is no stall on the first cycle after reset unless inputs newly create one.
- Multiple sources may select different stages in the same cycle. A source that matches an ALU op at k=1 and an older load at k=2 selects 1 with no stall.

Test Plan:
- Reset, then drive an ALU op rd=5 followed by an op reading rs0=5 (DEPTH=2) -> select0=1 in cycle 2; same rs0=5 one instruction later -> select0=2; fwd_cnt_o=2.
- Load rd=7 followed by an op reading rs1=7 -> stall_o=1 for exactly 1 cycle, select1=0 during the stall, select1=2 on the re-presented cycle; stall_cnt_o=1.
- Back-to-back writes to rd=3 (older ALU at stage 2, newer at stage 1) with rs0=rs1=3 -> select_o = {1,1}; rd=0 producer with rs0=0 -> select0=0; ex_rs_used_i=0 -> select 0.
- Load rd=9 then a dependent op with flush_i=1 in the same cycle -> stall_o=0, bubble enters s[1], stall_cnt_o unchanged.
- Stall pending (load rd=4 at s[1], consumer in EX), then assert rst_i=0 for one edge -> all selects 0, stall_o=0, both counters 0 with idle inputs after release.
- CNT_W=4, force 20 consecutive stall cycles -> stall_cnt_o holds at 15. Rebuild with NUM_SRC=3, DEPTH=3, LOAD_LAT=2: load rd=6, consumer two cycles later -> 1 stall, then select=3.
